// File: rtl/sig_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sig_mem_pkg
// Description : Shared memory map and writer FSM states for the signal-sample
//               memory. The writer (sig_sample_writer) and the VGA display
//               reader both import these constants, so the two sides agree on
//               where sweeps and per-sweep stat words live.
//               Map:  ECG_BASE  .. +DEPTH-1  ECG sweep buffer
//                     STAT_BASE .. +3        min_ecg, min_emg, max_ecg, max_emg
//                     EMG_BASE  .. +DEPTH-1  EMG sweep buffer
// Revision    : 1.0 - initial release
// ============================================================================
package sig_mem_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int SAMPLE_W_DEF = 12;
  localparam int DEPTH        = 320;
  localparam int IDX_W        = 9;   // width of the sweep slot index

  localparam logic [11:0] ECG_BASE  = 12'h559;
  localparam logic [11:0] EMG_BASE  = 12'h6AD;
  localparam logic [11:0] STAT_BASE = 12'h6A9;

  // Offsets of the per-sweep stat words from STAT_BASE
  localparam int MIN_ECG_OFF = 0;
  localparam int MIN_EMG_OFF = 1;
  localparam int MAX_ECG_OFF = 2;
  localparam int MAX_EMG_OFF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ECG  = 3'd1,
    WR_EMG  = 3'd2,
    WR_MINE = 3'd3,
    WR_MINM = 3'd4,
    WR_MAXE = 3'd5,
    WR_MAXM = 3'd6
  } wr_state_e;

endpackage : sig_mem_pkg
`default_nettype wire

// File: rtl/sig_minmax_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sig_minmax_tracker
// Description : Running unsigned min/max of one sample channel over a sweep.
//               The first update while invalid loads min=max=sample; later
//               updates only move min down / max up (ties keep the value).
//               clear invalidates the tracker for the next sweep.
// Ports       : clock, reset (async, active-low)
//               clear   - invalidate tracker (end of sweep)
//               update  - fold `sample` into min/max this cycle
//               sample  - sample value
//               min/max - current extremes, valid - at least one sample seen
// Revision    : 1.0 - initial release
// ============================================================================
module sig_minmax_tracker #(
  parameter int SAMPLE_W = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                update,
  output logic [SAMPLE_W-1:0] min,
  output logic [SAMPLE_W-1:0] max,
  output logic                valid
);

  logic [SAMPLE_W-1:0] min_q;
  logic [SAMPLE_W-1:0] max_q;
  logic                valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      min_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (update) begin
      if (!valid_q) begin
        min_q   <= sample;
        max_q   <= sample;
        valid_q <= 1'b1;
      end else begin
        if (sample < min_q) min_q <= sample;
        if (sample > max_q) max_q <= sample;
      end
    end
  end

  assign min   = min_q;
  assign max   = max_q;
  assign valid = valid_q;

endmodule : sig_minmax_tracker
`default_nettype wire

// File: rtl/sig_sample_writer.sv
`default_nettype none
// ============================================================================
// Module      : sig_sample_writer
// Description : Writer side of the shared signal-sample memory. Accepts
//               ECG/EMG pairs over valid/ready, writes them into two circular
//               sweep buffers through one write port (ECG then EMG), and after
//               the last slot of a sweep writes the four min/max stat words.
// Ports       : clock, reset (async, active-low)
//               s_valid/s_ready/s_ecg/s_emg - sample pair handshake
//               freeze                      - hold off new pairs
//               mem_addr/mem_wdata/mem_wen  - registered memory write port
//               wr_index                    - next sweep slot
//               sweep_done                  - pulse with the last stat write
// Revision    : 1.0 - initial release
// ============================================================================
module sig_sample_writer #(
  parameter int                ADDR_W    = sig_mem_pkg::ADDR_W_DEF,
  parameter int                SAMPLE_W  = sig_mem_pkg::SAMPLE_W_DEF,
  parameter int                DEPTH     = sig_mem_pkg::DEPTH,
  parameter logic [ADDR_W-1:0] ECG_BASE  = ADDR_W'(sig_mem_pkg::ECG_BASE),
  parameter logic [ADDR_W-1:0] EMG_BASE  = ADDR_W'(sig_mem_pkg::EMG_BASE),
  parameter logic [ADDR_W-1:0] STAT_BASE = ADDR_W'(sig_mem_pkg::STAT_BASE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_ecg,
  input  logic [SAMPLE_W-1:0] s_emg,
  input  logic                freeze,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                mem_wen,
  output logic [8:0]          wr_index,
  output logic                sweep_done
);

  import sig_mem_pkg::*;

  // Elaboration-time sanity of the memory map: the regions must not overlap
  // and the EMG buffer must fit in the address space.
  if (int'(ECG_BASE) + DEPTH > int'(STAT_BASE)) begin : g_chk_ecg_region
    $error("ECG buffer overlaps stat words");
  end
  if (int'(STAT_BASE) + 4 > int'(EMG_BASE)) begin : g_chk_stat_region
    $error("stat words overlap EMG buffer");
  end
  if (int'(EMG_BASE) + DEPTH > (1 << ADDR_W)) begin : g_chk_emg_region
    $error("EMG buffer exceeds address space");
  end
  if (DEPTH > (1 << IDX_W) || SAMPLE_W > 32) begin : g_chk_sizes
    $error("DEPTH or SAMPLE_W out of range");
  end

  wr_state_e           state_q, state_d;
  logic [IDX_W-1:0]    wr_index_q, wr_index_d;
  logic [SAMPLE_W-1:0] emg_q, emg_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_wen_q, mem_wen_d;
  logic                sweep_done_q, sweep_done_d;

  logic                accept;
  logic                trk_clear;
  logic [SAMPLE_W-1:0] min_ecg, max_ecg, min_emg, max_emg;
  logic                ecg_valid, emg_valid;

  assign s_ready   = (state_q == IDLE) && !freeze;
  assign accept    = s_valid && s_ready;
  // Trackers are dropped as the last stat word leaves, so the next sweep
  // starts from its own first sample.
  assign trk_clear = (state_q == WR_MAXM);

  sig_minmax_tracker #(.SAMPLE_W(SAMPLE_W)) u_trk_ecg (
    .clock  (clock),
    .reset  (reset),
    .clear  (trk_clear),
    .sample (s_ecg),
    .update (accept),
    .min    (min_ecg),
    .max    (max_ecg),
    .valid  (ecg_valid)
  );

  sig_minmax_tracker #(.SAMPLE_W(SAMPLE_W)) u_trk_emg (
    .clock  (clock),
    .reset  (reset),
    .clear  (trk_clear),
    .sample (s_emg),
    .update (accept),
    .min    (min_emg),
    .max    (max_emg),
    .valid  (emg_valid)
  );

  function automatic logic [31:0] zext(input logic [SAMPLE_W-1:0] v);
    return {{(32-SAMPLE_W){1'b0}}, v};
  endfunction

  // A sweep always contains at least one sample before its stats are
  // written; the valid gate only keeps stale tracker contents off the bus.
  function automatic logic [31:0] stat_word(input logic [SAMPLE_W-1:0] v,
                                            input logic ok);
    return ok ? zext(v) : 32'd0;
  endfunction

  // Outputs are registered: each branch loads the write that becomes visible
  // during the state being entered.
  always_comb begin
    state_d      = state_q;
    wr_index_d   = wr_index_q;
    emg_d        = emg_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = 1'b0;
    sweep_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // ECG data goes straight to the write register; only EMG needs
          // holding for the second write cycle.
          emg_d       = s_emg;
          mem_addr_d  = ECG_BASE + ADDR_W'(wr_index_q);
          mem_wdata_d = zext(s_ecg);
          mem_wen_d   = 1'b1;
          state_d     = WR_ECG;
        end
      end
      WR_ECG: begin
        mem_addr_d  = EMG_BASE + ADDR_W'(wr_index_q);
        mem_wdata_d = zext(emg_q);
        mem_wen_d   = 1'b1;
        state_d     = WR_EMG;
      end
      WR_EMG: begin
        if (wr_index_q == IDX_W'(DEPTH - 1)) begin
          wr_index_d  = '0;
          mem_addr_d  = STAT_BASE + ADDR_W'(MIN_ECG_OFF);
          mem_wdata_d = stat_word(min_ecg, ecg_valid);
          mem_wen_d   = 1'b1;
          state_d     = WR_MINE;
        end else begin
          wr_index_d  = wr_index_q + 1'b1;
          state_d     = IDLE;
        end
      end
      WR_MINE: begin
        mem_addr_d  = STAT_BASE + ADDR_W'(MIN_EMG_OFF);
        mem_wdata_d = stat_word(min_emg, emg_valid);
        mem_wen_d   = 1'b1;
        state_d     = WR_MINM;
      end
      WR_MINM: begin
        mem_addr_d  = STAT_BASE + ADDR_W'(MAX_ECG_OFF);
        mem_wdata_d = stat_word(max_ecg, ecg_valid);
        mem_wen_d   = 1'b1;
        state_d     = WR_MAXE;
      end
      WR_MAXE: begin
        mem_addr_d   = STAT_BASE + ADDR_W'(MAX_EMG_OFF);
        mem_wdata_d  = stat_word(max_emg, emg_valid);
        mem_wen_d    = 1'b1;
        sweep_done_d = 1'b1;
        state_d      = WR_MAXM;
      end
      WR_MAXM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_index_q   <= '0;
      emg_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_index_q   <= wr_index_d;
      emg_q        <= emg_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wen    = mem_wen_q;
  assign wr_index   = 9'(wr_index_q);
  assign sweep_done = sweep_done_q;

endmodule : sig_sample_writer
`default_nettype wire

// File: tb/tb_sig_sample_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sig_sample_writer
// Description : Directed self-checking bench for sig_sample_writer. Expected
//               addresses, data and stat words are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sig_sample_writer;

  logic        clock;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_ecg;
  logic [11:0] s_emg;
  logic        freeze;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [8:0]  wr_index;
  logic        sweep_done;

  int checks = 0;
  int errors = 0;

  sig_sample_writer dut (
    .clock      (clock),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_ecg      (s_ecg),
    .s_emg      (s_emg),
    .freeze     (freeze),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .wr_index   (wr_index),
    .sweep_done (sweep_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a pair at an IDLE-side negedge; returns at the negedge of the
  // WR_ECG cycle with s_valid dropped.
  task automatic send_pair(input logic [11:0] e, input logic [11:0] m);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ecg   = e;
    s_emg   = m;
    while (!s_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    if (n >= 50) begin
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "handshake never accepted");
    end
    @(negedge clock);
    s_valid = 1'b0;
  endtask

  function automatic logic [11:0] ecg_of(input int kind, input int i);
    case (kind)
      0:       return 12'(7 + i);
      1:       return 12'(100 + i);
      2:       return (i == 0) ? 12'h000 : (i == 1) ? 12'hFFF : 12'd1000;
      default: return 12'(10 + (i % 11));
    endcase
  endfunction

  function automatic logic [11:0] emg_of(input int kind, input int i);
    case (kind)
      0:       return 12'h100;
      1:       return 12'h800;
      2:       return (i == 0) ? 12'hFFF : (i == 1) ? 12'h000 : 12'd1000;
      default: return 12'(20 - (i % 11));
    endcase
  endfunction

  // Full 320-pair sweep starting at slot 0, checking the first write, the
  // last EMG write and the four stat writes.
  task automatic run_sweep(input int kind, input logic [31:0] mn_e, input logic [31:0] mn_m,
                           input logic [31:0] mx_e, input logic [31:0] mx_m);
    for (int i = 0; i < 320; i++) begin
      send_pair(ecg_of(kind, i), emg_of(kind, i));
      if (i == 0) begin
        chk("sweep_first_addr", 32'(mem_addr), 32'h559);
        chk("sweep_first_data", mem_wdata, 32'(ecg_of(kind, 0)));
      end
      @(negedge clock);
      if (i == 319) begin
        chk("sweep_last_emg_addr", 32'(mem_addr), 32'h7EC);
        @(negedge clock);
        chk("stat_min_ecg_addr", 32'(mem_addr), 32'h6A9);
        chk("stat_min_ecg", mem_wdata, mn_e);
        chk("stat_min_ecg_done", 32'(sweep_done), 32'd0);
        @(negedge clock);
        chk("stat_min_emg_addr", 32'(mem_addr), 32'h6AA);
        chk("stat_min_emg", mem_wdata, mn_m);
        @(negedge clock);
        chk("stat_max_ecg_addr", 32'(mem_addr), 32'h6AB);
        chk("stat_max_ecg", mem_wdata, mx_e);
        @(negedge clock);
        chk("stat_max_emg_addr", 32'(mem_addr), 32'h6AC);
        chk("stat_max_emg", mem_wdata, mx_m);
        chk("stat_max_emg_wen", 32'(mem_wen), 32'd1);
        chk("sweep_done_pulse", 32'(sweep_done), 32'd1);
      end
      @(negedge clock);
    end
    chk("sweep_end_wen", 32'(mem_wen), 32'd0);
    chk("sweep_end_done", 32'(sweep_done), 32'd0);
    chk("sweep_end_index", 32'(wr_index), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    s_valid = 1'b0;
    s_ecg   = '0;
    s_emg   = '0;
    freeze  = 1'b0;

    // Reset state
    #2;
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_index", 32'(wr_index), 32'd0);
    chk("rst_done", 32'(sweep_done), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single pair
    send_pair(12'h123, 12'h456);
    chk("p1_ecg_wen", 32'(mem_wen), 32'd1);
    chk("p1_ecg_addr", 32'(mem_addr), 32'h559);
    chk("p1_ecg_data", mem_wdata, 32'h123);
    @(negedge clock);
    chk("p1_emg_wen", 32'(mem_wen), 32'd1);
    chk("p1_emg_addr", 32'(mem_addr), 32'h6AD);
    chk("p1_emg_data", mem_wdata, 32'h456);
    @(negedge clock);
    chk("p1_idle_wen", 32'(mem_wen), 32'd0);
    chk("p1_index", 32'(wr_index), 32'd1);
    chk("p1_addr_hold", 32'(mem_addr), 32'h6AD);

    // s_valid held for three pairs: ready one cycle in three
    s_valid = 1'b1;
    for (int p = 0; p < 3; p++) begin
      s_ecg = 12'(16 + p);
      s_emg = 12'(32 + p);
      chk("b2b_ready_idle", 32'(s_ready), 32'd1);
      @(negedge clock);
      chk("b2b_ready_ecg", 32'(s_ready), 32'd0);
      chk("b2b_ecg_addr", 32'(mem_addr), 32'(12'h55A + p));
      chk("b2b_ecg_data", mem_wdata, 32'(16 + p));
      @(negedge clock);
      chk("b2b_ready_emg", 32'(s_ready), 32'd0);
      chk("b2b_emg_addr", 32'(mem_addr), 32'(12'h6AE + p));
      chk("b2b_emg_data", mem_wdata, 32'(32 + p));
      @(negedge clock);
    end
    s_valid = 1'b0;
    chk("b2b_index", 32'(wr_index), 32'd4);

    // freeze during WR_ECG: EMG write completes, then hold
    send_pair(12'h031, 12'h032);
    freeze = 1'b1;
    chk("frz_ecg_addr", 32'(mem_addr), 32'h55D);
    @(negedge clock);
    chk("frz_emg_wen", 32'(mem_wen), 32'd1);
    chk("frz_emg_addr", 32'(mem_addr), 32'h6B1);
    chk("frz_emg_data", mem_wdata, 32'h032);
    s_valid = 1'b1;
    s_ecg   = 12'h041;
    s_emg   = 12'h042;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("frz_hold_ready", 32'(s_ready), 32'd0);
      chk("frz_hold_wen", 32'(mem_wen), 32'd0);
      chk("frz_hold_index", 32'(wr_index), 32'd5);
    end
    freeze = 1'b0;
    #1;
    chk("frz_release_ready", 32'(s_ready), 32'd1);
    @(negedge clock);
    s_valid = 1'b0;
    chk("frz_next_addr", 32'(mem_addr), 32'h55E);
    chk("frz_next_data", mem_wdata, 32'h041);
    @(negedge clock);
    chk("frz_next_emg", mem_wdata, 32'h042);
    @(negedge clock);
    chk("frz_next_index", 32'(wr_index), 32'd6);

    // Advance to slot 200 with extreme values, then reset mid-write
    for (int k = 0; k < 400 && wr_index != 9'd200; k++) begin
      send_pair((k % 2) ? 12'hFFF : 12'h000, (k % 2) ? 12'h000 : 12'hFFF);
      @(negedge clock);
      @(negedge clock);
    end
    chk("abort_slot", 32'(wr_index), 32'd200);
    send_pair(12'hFFF, 12'h000);
    chk("abort_ecg_wen", 32'(mem_wen), 32'd1);
    chk("abort_ecg_addr", 32'(mem_addr), 32'h621);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_async_wen", 32'(mem_wen), 32'd0);
    chk("abort_async_addr", 32'(mem_addr), 32'd0);
    chk("abort_async_index", 32'(wr_index), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_no_residual", 32'(mem_wen), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);

    // Sweep A: first pair ecg=7 at 0x559; stats ignore pre-reset extremes
    run_sweep(0, 32'd7, 32'h100, 32'd326, 32'h100);
    // Sweep B: ecg ramp 100..419, emg constant 0x800
    run_sweep(1, 32'd100, 32'h800, 32'd419, 32'h800);
    // Sweep C spans full range, sweep D spans 10..20 independently
    run_sweep(2, 32'd0, 32'd0, 32'hFFF, 32'hFFF);
    run_sweep(3, 32'd10, 32'd10, 32'd20, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sig_sample_writer
`default_nettype wire
